// File: rtl/mist1032isa_uart_transmitter.sv
// rtl/mist1032isa_uart_transmitter.sv - FIFO-buffered UART transmitter, 4 b_bd_clock cycles per bit
//
// Buffers bytes in a small circular FIFO and serialises each one onto oUART_TXD
// as start, 8 data bits (LSB first), optional parity, and 1 or 2 stop bits.
//
// Ports:
//   b_bd_clock  x4 baud tick clock
//   inRESET     asynchronous active-low reset
//   iTX_VALID   byte write request
//   iTX_DATA    byte to send
//   oTX_READY   FIFO not full; a write is taken on iTX_VALID && oTX_READY
//   oTX_BUSY    frame in progress or FIFO not empty
//   oTX_EMPTY   FIFO empty
//   oUART_TXD   registered serial line, idle high
module mist1032isa_uart_transmitter #(
    parameter int         FIFO_DEPTH_N = 2,
    parameter int         STOP_BITS    = 1,
    parameter logic [1:0] PARITY       = 2'h0
) (
    input  logic       b_bd_clock,
    input  logic       inRESET,
    input  logic       iTX_VALID,
    input  logic [7:0] iTX_DATA,
    output logic       oTX_READY,
    output logic       oTX_BUSY,
    output logic       oTX_EMPTY,
    output logic       oUART_TXD
);

    localparam int              PW       = FIFO_DEPTH_N + 1;
    localparam int              DEPTH    = 1 << FIFO_DEPTH_N;
    localparam logic [PW-1:0]   DEPTH_W  = PW'(DEPTH);
    localparam logic [PW-1:0]   LAST_W   = PW'(DEPTH - 1);
    localparam logic [PW-1:0]   ONE_W    = PW'(1);
    localparam bit              PAR_EN   = (PARITY == 2'd1) || (PARITY == 2'd2);
    localparam bit              PAR_ODD  = (PARITY == 2'd2);
    localparam bit              TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sub_q, sub_d;
    logic [2:0]      idx_q, idx_d;
    logic            stop_q, stop_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            txd_q, txd_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    logic            push;
    logic            pop;
    logic [7:0]      head;

    assign head      = mem_q[rptr_q[FIFO_DEPTH_N-1:0]];
    assign oTX_READY = (count_q != DEPTH_W);
    assign oTX_EMPTY = (count_q == '0);
    assign oTX_BUSY  = (state_q != ST_IDLE) || !oTX_EMPTY;
    assign oUART_TXD = txd_q;

    // FIFO: pointers wrap at DEPTH-1; a write while full is dropped even if
    // the FSM pops in the same cycle, because oTX_READY reflects the old count.
    always_comb begin
        push    = iTX_VALID && oTX_READY;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[wptr_q[FIFO_DEPTH_N-1:0]] = iTX_DATA;
            wptr_d = (wptr_q == LAST_W) ? '0 : wptr_q + ONE_W;
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_W) ? '0 : rptr_q + ONE_W;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_W;
            2'b01:   count_d = count_q - ONE_W;
            default: count_d = count_q;
        endcase
    end

    // Serialiser. sub counts the four ticks of each bit; every state acts on
    // sub == 3 and the natural wrap of sub restarts the next bit at 0.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q + 2'd1;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                sub_d = 2'd0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = PAR_ODD ? ~^head : ^head;
                    txd_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (sub_q == 2'd3) begin
                    txd_d   = shift_q[0];
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sub_q == 2'd3) begin
                    if (idx_q == 3'd7) begin
                        stop_d = 1'b0;
                        if (PAR_EN) begin
                            txd_d   = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sub_q == 2'd3) begin
                    txd_d   = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sub_q == 2'd3) begin
                    if (TWO_STOP && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (count_q != '0) begin
                        // Back-to-back: the next start bit follows with no idle gap.
                        pop     = 1'b1;
                        shift_d = head;
                        par_d   = PAR_ODD ? ~^head : ^head;
                        txd_d   = 1'b0;
                        sub_d   = 2'd0;
                        state_d = ST_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge b_bd_clock or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            sub_q   <= 2'd0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_mist1032isa_uart_transmitter.sv
// tb/tb_mist1032isa_uart_transmitter.sv - scoreboard bench for mist1032isa_uart_transmitter
module tb_mist1032isa_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       ready_a, busy_a, empty_a, txd_a;
    logic       valid_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       ready_b, busy_b, empty_b, txd_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    always #5 clk = ~clk;

    mist1032isa_uart_transmitter dut_a (
        .b_bd_clock (clk),
        .inRESET    (rst_n),
        .iTX_VALID  (valid_a),
        .iTX_DATA   (data_a),
        .oTX_READY  (ready_a),
        .oTX_BUSY   (busy_a),
        .oTX_EMPTY  (empty_a),
        .oUART_TXD  (txd_a)
    );

    mist1032isa_uart_transmitter #(
        .FIFO_DEPTH_N (2),
        .STOP_BITS    (2),
        .PARITY       (2'h2)
    ) dut_b (
        .b_bd_clock (clk),
        .inRESET    (rst_n),
        .iTX_VALID  (valid_b),
        .iTX_DATA   (data_b),
        .oTX_READY  (ready_b),
        .oTX_BUSY   (busy_b),
        .oTX_EMPTY  (empty_b),
        .oUART_TXD  (txd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line receiver: decodes frames sampled on the falling edge, requires each
    // bit to hold for exactly four samples, and compares with the scoreboard.
    task automatic monitor(input bit b);
        int         nb;
        int         cyc;
        bit         act;
        logic       t;
        logic       cur;
        logic [11:0] fr;
        logic [7:0] d;
        logic [7:0] exp_d;
        int         ones;
        nb  = b ? 12 : 10;
        act = 1'b0;
        cyc = 0;
        cur = 1'b1;
        fr  = '0;
        forever begin
            @(negedge clk);
            t = b ? txd_b : txd_a;
            if (!rst_n) begin
                act = 1'b0;
            end else begin
                if (!act && t == 1'b0) begin
                    act = 1'b1;
                    cyc = 0;
                end
                if (act) begin
                    if (cyc % 4 == 0) cur = t;
                    else check_eq(b ? "b_bit_hold" : "a_bit_hold", t, cur);
                    if (cyc % 4 == 3) fr[cyc/4] = cur;
                    if (cyc == 4*nb - 1) begin
                        act = 1'b0;
                        check_eq(b ? "b_start" : "a_start", fr[0], 1'b0);
                        for (int k = 0; k < 8; k++) d[k] = fr[1+k];
                        check_eq(b ? "b_stop" : "a_stop", fr[nb-1], 1'b1);
                        if (b) begin
                            ones = $countones(d);
                            check_eq("b_parity", fr[9], (ones % 2 == 0) ? 1'b1 : 1'b0);
                            check_eq("b_stop1", fr[10], 1'b1);
                            check_eq("b_sb_has_entry", (sb_b.size() > 0), 1'b1);
                            if (sb_b.size() > 0) begin
                                exp_d = sb_b.pop_front();
                                check_eq("b_rx_byte", d, exp_d);
                            end
                        end else begin
                            check_eq("a_sb_has_entry", (sb_a.size() > 0), 1'b1);
                            if (sb_a.size() > 0) begin
                                exp_d = sb_a.pop_front();
                                check_eq("a_rx_byte", d, exp_d);
                            end
                        end
                    end
                    cyc++;
                end
            end
        end
    endtask

    task automatic send_a(input logic [7:0] d, input bit track, output bit acc);
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = d;
        acc     = ready_a;
        @(posedge clk);
        if (acc && track) sb_a.push_back(d);
    endtask

    task automatic send_b(input logic [7:0] d, output bit acc);
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = d;
        acc     = ready_b;
        @(posedge clk);
        if (acc) sb_b.push_back(d);
    endtask

    // Counts falling edges with busy high, starting at the next falling edge.
    task automatic wait_idle(input bit b, output int n);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            valid_b = 1'b0;
            if (!(b ? busy_b : busy_a)) break;
            n++;
        end
        check_eq("idle_timeout", (n < 3000), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        int n_acc;
        int n_low;

        fork
            monitor(1'b0);
            monitor(1'b1);
        join_none

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_txd", txd_a, 1'b1);
        check_eq("rst_ready", ready_a, 1'b1);
        check_eq("rst_empty", empty_a, 1'b1);
        check_eq("rst_busy", busy_a, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte A5: start falls two edges after accept, busy 41 cycles
        send_a(8'hA5, 1'b1, acc);
        check_eq("a5_accept", acc, 1'b1);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            if (n == 0) begin
                check_eq("a5_txd_e0", txd_a, 1'b1);
                check_eq("a5_empty_e0", empty_a, 1'b0);
            end
            if (n == 1) begin
                check_eq("a5_txd_e1", txd_a, 1'b0);
                check_eq("a5_empty_e1", empty_a, 1'b1);
            end
            if (!busy_a) break;
            n++;
        end
        check_eq("a5_busy_len", n, 41);

        // Burst of five writes: all accepted, frames back-to-back
        n_acc = 0;
        for (int i = 1; i <= 5; i++) begin
            send_a(8'(i), 1'b1, acc);
            if (acc) n_acc++;
        end
        check_eq("burst_accepts", n_acc, 5);
        wait_idle(1'b0, n);
        check_eq("burst_busy_len", n, 197);
        check_eq("burst_sb_drained", sb_a.size(), 0);

        // Fill the FIFO, then hold EE while full
        send_a(8'h11, 1'b1, acc);
        send_a(8'h22, 1'b1, acc);
        send_a(8'h33, 1'b1, acc);
        send_a(8'h44, 1'b1, acc);
        send_a(8'h55, 1'b1, acc);
        n_low = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready_a) begin
                valid_a = 1'b0;
                break;
            end
            valid_a = 1'b1;
            data_a  = 8'hEE;
            n_low++;
        end
        check_eq("full_ready_low_len", n_low, 37);
        wait_idle(1'b0, n);
        check_eq("full_sb_drained", sb_a.size(), 0);

        // Odd parity, two stop bits: 48-cycle frame
        send_b(8'h07, acc);
        check_eq("par_accept", acc, 1'b1);
        wait_idle(1'b1, n);
        check_eq("par_busy_len", n, 49);
        check_eq("par_sb_drained", sb_b.size(), 0);

        // Reset during data bit 3 of 8'h00
        send_a(8'h00, 1'b0, acc);
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
        end
        check_eq("rmid_txd_before", txd_a, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("rmid_txd_async", txd_a, 1'b1);
        check_eq("rmid_empty", empty_a, 1'b1);
        check_eq("rmid_busy", busy_a, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_low = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (txd_a == 1'b0) n_low++;
        end
        check_eq("rmid_no_restart", n_low, 0);
        check_eq("rmid_empty_after", empty_a, 1'b1);

        // Pointer wrap: ten distinct bytes with random gaps
        for (int i = 0; i < 10; i++) begin
            int gap;
            int tries;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                valid_a = 1'b0;
            end
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 200) begin
                send_a(8'(8'h30 + i * 7), 1'b1, acc);
                tries++;
            end
            check_eq("wrap_accept", acc, 1'b1);
        end
        wait_idle(1'b0, n);
        check_eq("wrap_sb_drained", sb_a.size(), 0);
        check_eq("wrap_empty", empty_a, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
